video_memport: RTL
==================

// Module: video_memport
// PURPOSE
//  DRAM-side responder for the video fetch port: generates the 4-clk DRAM cycle phase strobes and the 8-cycle slot count.
//  Grants video reads at the requested bandwidth (video_go/video_bw) and fills the remaining cycles with CPU accesses.
//  Returns video_next (address taken) and video_strobe/video_data (read data). Sits between the video subsystem and the DRAM controller.
// PARAMETERS
//  AW  21  DRAM word-address width
//  DW  16  DRAM data width
// PORTS
//  clk           in   1   28 MHz clock
//  rst_n         in   1   asynchronous active-low reset
//  cbeg          out  1   phase strobes, each one clk, period 4: cbeg->post_cbeg->pre_cend->cend
//  post_cbeg     out  1
//  pre_cend      out  1
//  cend          out  1
//  video_go      in   1   video requests DRAM cycles
//  video_bw      in   2   00=1/8, 01=1/4, 10=1/2, 11=every cycle
//  video_addr    in   AW  video read address
//  video_next    out  1   video_addr consumed; fetch advances its address
//  video_strobe  out  1   video_data valid this clk
//  video_data    out  DW  registered read data
//  cpu_req       in   1   CPU access pending
//  cpu_rnw       in   1   1=read, 0=write
//  cpu_addr      in   AW
//  cpu_wrdata    in   DW
//  cpu_next      out  1   CPU request consumed
//  cpu_strobe    out  1   cpu_rddata valid this clk (reads only)
//  cpu_rddata    out  DW
//  dram_req      out  1   access active for the whole 4-clk cycle
//  dram_rnw      out  1
//  dram_addr     out  AW
//  dram_wrdata   out  DW
//  dram_rddata   in   DW  valid at the cend clk of the access cycle
// BEHAVIOUR
//  - Reset: all outputs 0, phase=3 (cend position), slot=7, no access owned. Reset is asynchronous at any point and aborts any in-flight access.
//    No strobe is emitted for the aborted cycle.
//  - Phase strobes are registered. The first clk after rst_n rises has cbeg=1; strict 4-clk period afterwards.
//  - slot[2:0] increments at every cend and wraps 7->0.
//    The first cycle after reset is slot 0.
//  - Decision at the pre_cend clk, for the next cycle with slot nslot=slot+1:
//    - vslot = bw00: nslot==0; bw01: nslot[1:0]==0; bw10: nslot[0]==0; bw11: 1.
//    - Video owns the cycle if video_go && vslot.
//    - Otherwise the CPU owns it if cpu_req.
//    - Otherwise the cycle is idle. An unused video slot goes to the CPU.
//  - At the cend clk preceding the owned cycle:
//    - video_next or cpu_next pulses for 1 clk.
//    - The address, rnw and wrdata are latched into dram_* on that edge.
//    - dram_req is 1 for the owned cycle's 4 clks (cbeg..cend) and 0 in idle cycles.
//    - Video cycles always have dram_rnw=1.
//  - Read return: dram_rddata is captured on the edge ending the cend clk of the access cycle.
//    video_strobe or cpu_strobe is high during the following cbeg clk.
//    Latency: strobe is 5 clks after the matching next pulse.
//    CPU writes produce no strobe.
//  - video_data and cpu_rddata hold their value until the next respective capture.
//  - video_go or video_bw changes are sampled only at pre_cend.
//    A granted cycle always completes and strobes even if video_go drops.
//  - At most one next pulse and one strobe per 4 clks. video_next and cpu_next are never simultaneous; neither are the two strobes.
// STRUCTURE
//  - Shared include: bandwidth encodings (BW_1_8..BW_1_1) and phase indices (PH_CBEG..PH_CEND).
//  - Sub-module video_memport_phase: phase counter, registered strobes, slot counter, vslot decode.
//  - Top level: ownership FSM (IDLE/VID/CPU per cycle) plus the data-return pipeline.
// TESTING
//  1. Reset release, no requests:
//     cbeg at clk 1 after release, period 4; slot 0..7 then back to 0 after 32 clks; dram_req stays 0.
//  2. bw=00, video_go=1, addr 0x00100 (bench increments on next), dram_rddata=16'hA55A:
//     exactly one video_next per 32 clks, at the cend of slot 7; dram_addr=0x00100 in slot 0;
//     video_strobe 5 clks later with video_data=16'hA55A.
//  3. bw=01 plus cpu_req held at 1:
//     video owns slots 0 and 4; CPU owns 1,2,3,5,6,7; 2 video_next and 6 cpu_next per 32 clks.
//  4. Video and CPU both requesting in a video slot:
//     video wins; cpu_next is delayed to the next non-video cycle; cpu_addr is unchanged in dram_addr when that cycle is granted.
//  5. CPU write, addr 0x1ABCD, data 16'h1234:
//     dram_rnw=0, dram_addr=0x1ABCD, dram_wrdata=16'h1234 for 4 clks; cpu_strobe never asserts.
//  6. rst_n low at post_cbeg of a granted video read:
//     all outputs 0 immediately; after release, no video_strobe for the aborted cycle and the phase sequence restarts at cbeg.

Source files
------------

// File: rtl/video_memport_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : video_memport_pkg
//  Brief   : Shared encodings for the video memory port: bandwidth codes,
//            DRAM cycle phase indices, cycle ownership and slot decode.
//  Rev     : 1.0  initial release
// ============================================================================
package video_memport_pkg;

    localparam logic [1:0] BW_1_8 = 2'b00;
    localparam logic [1:0] BW_1_4 = 2'b01;
    localparam logic [1:0] BW_1_2 = 2'b10;
    localparam logic [1:0] BW_1_1 = 2'b11;

    localparam logic [1:0] PH_CBEG = 2'd0;
    localparam logic [1:0] PH_POST = 2'd1;
    localparam logic [1:0] PH_PRE  = 2'd2;
    localparam logic [1:0] PH_CEND = 2'd3;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } own_e;

    // True when slot number nslot belongs to video at bandwidth bw.
    function automatic logic slot_is_video(input logic [1:0] bw, input logic [2:0] nslot);
        logic v;
        case (bw)
            BW_1_8:  v = (nslot == 3'd0);
            BW_1_4:  v = (nslot[1:0] == 2'd0);
            BW_1_2:  v = (nslot[0] == 1'b0);
            default: v = 1'b1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_memport_phase.sv
`default_nettype none
// ============================================================================
//  Module  : video_memport_phase
//  Brief   : 4-clk DRAM cycle phase generator with registered strobes, 8-cycle
//            slot counter and video-slot decode for the upcoming cycle.
//  Rev     : 1.0  initial release
// ============================================================================
module video_memport_phase
    import video_memport_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_bw,
    output logic       o_cbeg,
    output logic       o_post_cbeg,
    output logic       o_pre_cend,
    output logic       o_cend,
    output logic       o_vslot
);

    logic [1:0] r_phase;
    logic [2:0] r_slot;
    logic       r_cbeg;
    logic       r_post_cbeg;
    logic       r_pre_cend;
    logic       r_cend;
    logic [2:0] w_nslot;

    // Reset parks at the cend position so the first edge after release
    // starts a fresh cycle in slot 0; the strobes themselves stay low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_CEND;
            r_slot      <= 3'd7;
            r_cbeg      <= 1'b0;
            r_post_cbeg <= 1'b0;
            r_pre_cend  <= 1'b0;
            r_cend      <= 1'b0;
        end else begin
            r_phase     <= r_phase + 2'd1;
            r_cbeg      <= (r_phase == PH_CEND);
            r_post_cbeg <= (r_phase == PH_CBEG);
            r_pre_cend  <= (r_phase == PH_POST);
            r_cend      <= (r_phase == PH_PRE);
            if (r_phase == PH_CEND) begin
                r_slot <= r_slot + 3'd1;
            end
        end
    end

    assign w_nslot     = r_slot + 3'd1;
    assign o_vslot     = slot_is_video(i_bw, w_nslot);
    assign o_cbeg      = r_cbeg;
    assign o_post_cbeg = r_post_cbeg;
    assign o_pre_cend  = r_pre_cend;
    assign o_cend      = r_cend;

endmodule
`default_nettype wire

// File: rtl/video_memport.sv
`default_nettype none
// ============================================================================
//  Module  : video_memport
//  Brief   : DRAM-side responder arbitrating each 4-clk DRAM cycle between
//            the video fetch port and CPU accesses, with read-data return.
//  Rev     : 1.0  initial release
// ============================================================================
module video_memport
    import video_memport_pkg::*;
#(
    parameter int AW = 21,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          cbeg,
    output logic          post_cbeg,
    output logic          pre_cend,
    output logic          cend,
    input  logic          video_go,
    input  logic [1:0]    video_bw,
    input  logic [AW-1:0] video_addr,
    output logic          video_next,
    output logic          video_strobe,
    output logic [DW-1:0] video_data,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wrdata,
    output logic          cpu_next,
    output logic          cpu_strobe,
    output logic [DW-1:0] cpu_rddata,
    output logic          dram_req,
    output logic          dram_rnw,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_wrdata,
    input  logic [DW-1:0] dram_rddata
);

    logic          w_pre_cend;
    logic          w_cend;
    logic          w_vslot;

    own_e          r_state;
    own_e          r_pend;
    own_e          w_state_nxt;
    own_e          w_pend_nxt;

    logic [AW-1:0] r_addr;
    logic          r_rnw;
    logic [DW-1:0] r_wrdata;
    logic          r_vstrobe;
    logic          r_cstrobe;
    logic [DW-1:0] r_vdata;
    logic [DW-1:0] r_cdata;

    video_memport_phase u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_bw        (video_bw),
        .o_cbeg      (cbeg),
        .o_post_cbeg (post_cbeg),
        .o_pre_cend  (w_pre_cend),
        .o_cend      (w_cend),
        .o_vslot     (w_vslot)
    );

    assign pre_cend = w_pre_cend;
    assign cend     = w_cend;

    // r_state owns the current DRAM cycle; r_pend is the owner chosen at
    // pre_cend for the cycle that starts after the coming cend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OWN_IDLE;
            r_pend  <= OWN_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        if (w_pre_cend) begin
            if (video_go && w_vslot) begin
                w_pend_nxt = OWN_VID;
            end else if (cpu_req) begin
                w_pend_nxt = OWN_CPU;
            end else begin
                w_pend_nxt = OWN_IDLE;
            end
        end
        if (w_cend) begin
            w_state_nxt = r_pend;
        end
    end

    always_comb begin
        dram_req   = (r_state != OWN_IDLE);
        video_next = w_cend && (r_pend == OWN_VID);
        cpu_next   = w_cend && (r_pend == OWN_CPU);
    end

    // Request latch and read return both happen on the edge that ends cend:
    // the finishing cycle's read data is captured while the next cycle's
    // request is taken from whichever port was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_rnw     <= 1'b0;
            r_wrdata  <= '0;
            r_vstrobe <= 1'b0;
            r_cstrobe <= 1'b0;
            r_vdata   <= '0;
            r_cdata   <= '0;
        end else begin
            r_vstrobe <= w_cend && (r_state == OWN_VID);
            r_cstrobe <= w_cend && (r_state == OWN_CPU) && r_rnw;
            if (w_cend && (r_state == OWN_VID)) begin
                r_vdata <= dram_rddata;
            end
            if (w_cend && (r_state == OWN_CPU) && r_rnw) begin
                r_cdata <= dram_rddata;
            end
            if (w_cend) begin
                case (r_pend)
                    OWN_VID: begin
                        r_addr <= video_addr;
                        r_rnw  <= 1'b1;
                    end
                    OWN_CPU: begin
                        r_addr   <= cpu_addr;
                        r_rnw    <= cpu_rnw;
                        r_wrdata <= cpu_wrdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dram_rnw     = r_rnw;
    assign dram_addr    = r_addr;
    assign dram_wrdata  = r_wrdata;
    assign video_strobe = r_vstrobe;
    assign video_data   = r_vdata;
    assign cpu_strobe   = r_cstrobe;
    assign cpu_rddata   = r_cdata;

endmodule
`default_nettype wire
